// File: rtl/somador_core.sv
// Registered adder behind the pad ring: resamples asynchronous pad operands,
// waits for them to settle, then commits the sum with a one-cycle update strobe.
module somador_core #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_i_Y,
    input  logic [WIDTH-1:0] b_i_Y,
    input  logic             carry_i_Y,
    output logic [WIDTH-1:0] sum_o_A,
    output logic             carry_o_A,
    output logic             upd_o
);

    localparam int         SW        = 2 * WIDTH + 1;
    localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYCLES);

    logic [SW-1:0]    smp_q;
    logic [SW-1:0]    prev_q;
    logic [SW-1:0]    com_q;
    logic [SW-1:0]    com_d;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic             carry_d;
    logic             upd_q;
    logic             upd_d;

    logic             same;
    logic             commit;
    logic [WIDTH-1:0] smp_a;
    logic [WIDTH-1:0] smp_b;
    logic             smp_c;
    logic [WIDTH:0]   total;

    assign smp_a = smp_q[WIDTH-1:0];
    assign smp_b = smp_q[2*WIDTH-1:WIDTH];
    assign smp_c = smp_q[SW-1];

    // Full WIDTH+1 result so the worst case (all ones + all ones + 1) keeps its carry.
    assign total = {1'b0, smp_a} + {1'b0, smp_b} + {{WIDTH{1'b0}}, smp_c};

    assign same   = (smp_q == prev_q);
    assign commit = same && (cnt_q == STABLE_LIM) && (smp_q != com_q);

    always_comb begin
        cnt_d   = cnt_q;
        com_d   = com_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        upd_d   = 1'b0;

        if (!same) begin
            cnt_d = 4'd0;
        end else if (cnt_q < STABLE_LIM) begin
            cnt_d = cnt_q + 4'd1;
        end

        if (commit) begin
            com_d   = smp_q;
            sum_d   = total[WIDTH-1:0];
            carry_d = total[WIDTH];
            upd_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q   <= '0;
            prev_q  <= '0;
            com_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            smp_q   <= {carry_i_Y, b_i_Y, a_i_Y};
            prev_q  <= smp_q;
            com_q   <= com_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            upd_q   <= upd_d;
        end
    end

    assign sum_o_A   = sum_q;
    assign carry_o_A = carry_q;
    assign upd_o     = upd_q;

endmodule
